// File: rtl/ysyx_22050019_scoreboard_pkg.sv
// Shared definitions for the ID-stage scoreboard: register address width, register count, default counter width.
// The optional perf counters are controlled by the YSYX_22050019_SB_PERF_EN macro, tested in the scoreboard top.
package ysyx_22050019_defines;

    localparam int REG_ADDR_W = 5;
    localparam int SB_NREG    = 32;
    localparam int SB_CNT_W   = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // x0 is hardwired zero, so an access to it never creates a dependency
    function automatic logic reg_tracked(input logic en, input reg_addr_t addr);
        return en && (addr != '0);
    endfunction

endpackage

// File: rtl/ysyx_22050019_sb_entry.sv
// One architectural register's scoreboard slot: in-flight writer count and pending-load flag.
module ysyx_22050019_sb_entry
    import ysyx_22050019_defines::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic             issue_load,
    input  logic             ld_done,
    input  logic             retire,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt,
    output logic             ld_pend
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ld_pend_q, ld_pend_d;

    always_comb begin
        cnt_d     = cnt_q;
        ld_pend_d = ld_pend_q;
        // Issue and retire in the same cycle cancel; a stray retire at zero holds
        if (issue && !retire) begin
            cnt_d = cnt_q + 1'b1;
        end else if (retire && !issue && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (ld_done) begin
            ld_pend_d = 1'b0;
        end
        if (issue) begin
            ld_pend_d = issue_load;
        end
        if (flush) begin
            cnt_d     = '0;
            ld_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            ld_pend_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ld_pend_q <= ld_pend_d;
        end
    end

    assign cnt     = cnt_q;
    assign ld_pend = ld_pend_q;

`ifndef SYNTHESIS
    retire_underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(retire && !issue && !flush && cnt_q == '0));
`endif

endmodule

// File: rtl/ysyx_22050019_scoreboard.sv
// ID-stage scoreboard: stalls issue on an unreturned load producer or a saturated in-flight counter.
// Define YSYX_22050019_SB_PERF_EN to add the perf_stall_cnt / perf_ovf_cnt counters.
module ysyx_22050019_scoreboard
    import ysyx_22050019_defines::*;
#(
    parameter int CNT_W = SB_CNT_W,
    parameter int NREG  = SB_NREG
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic                  id_rs1_en,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs2_en,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_rd_wen,
    input  logic                  id_is_load,
    input  logic                  lsu_ld_done,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  flush,
    output logic                  stall_rs1,
    output logic                  stall_rs2
`ifdef YSYX_22050019_SB_PERF_EN
    ,
    output logic [63:0]           perf_stall_cnt,
    output logic [31:0]           perf_ovf_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0]            ld_pend;
    logic                       ovf;
    logic                       fire;

    always_comb begin
        stall_rs1 = reg_tracked(id_rs1_en, id_rs1) && ld_pend[id_rs1];
        stall_rs2 = reg_tracked(id_rs2_en, id_rs2) && ld_pend[id_rs2];
        ovf       = reg_tracked(id_rd_wen, id_rd) && (cnt[id_rd] == CNT_MAX);
        // Flush forces ready so ID can drain; fire still masks the issue
        id_ready  = !(stall_rs1 || stall_rs2 || ovf) || flush;
        fire      = id_valid && id_ready && !flush;
    end

    assign cnt[0]     = '0;
    assign ld_pend[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        logic issue_r, ld_done_r, retire_r;

        assign issue_r   = fire && id_rd_wen && (id_rd == REG_ADDR_W'(r));
        assign ld_done_r = lsu_ld_done && (lsu_rd == REG_ADDR_W'(r));
        assign retire_r  = wb_valid && (wb_rd == REG_ADDR_W'(r));

        ysyx_22050019_sb_entry #(
            .CNT_W(CNT_W)
        ) u_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .issue      (issue_r),
            .issue_load (id_is_load),
            .ld_done    (ld_done_r),
            .retire     (retire_r),
            .flush      (flush),
            .cnt        (cnt[r]),
            .ld_pend    (ld_pend[r])
        );
    end

`ifdef YSYX_22050019_SB_PERF_EN
    logic [63:0] perf_stall_cnt_q, perf_stall_cnt_d;
    logic [31:0] perf_ovf_cnt_q, perf_ovf_cnt_d;

    // Counters survive flush so they measure whole-run stall pressure
    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q;
        perf_ovf_cnt_d   = perf_ovf_cnt_q;
        if (id_valid && !id_ready && !flush) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 64'd1;
            if (ovf) begin
                perf_ovf_cnt_d = perf_ovf_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt_q <= '0;
            perf_ovf_cnt_q   <= '0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
            perf_ovf_cnt_q   <= perf_ovf_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_ovf_cnt   = perf_ovf_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_22050019_scoreboard.sv
// Table-driven bench for ysyx_22050019_scoreboard (default CNT_W=2), plus mid-run reset sequence.
module tb_ysyx_22050019_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_ready;
    logic [4:0] id_rs1, id_rs2, id_rd, lsu_rd, wb_rd;
    logic       id_rs1_en, id_rs2_en, id_rd_wen, id_is_load;
    logic       lsu_ld_done, wb_valid, flush;
    logic       stall_rs1, stall_rs2;
`ifdef YSYX_22050019_SB_PERF_EN
    logic [63:0] perf_stall_cnt;
    logic [31:0] perf_ovf_cnt;
`endif

    always #5 clk = ~clk;

    ysyx_22050019_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_rs1      (id_rs1),
        .id_rs1_en   (id_rs1_en),
        .id_rs2      (id_rs2),
        .id_rs2_en   (id_rs2_en),
        .id_rd       (id_rd),
        .id_rd_wen   (id_rd_wen),
        .id_is_load  (id_is_load),
        .lsu_ld_done (lsu_ld_done),
        .lsu_rd      (lsu_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .flush       (flush),
        .stall_rs1   (stall_rs1),
        .stall_rs2   (stall_rs2)
`ifdef YSYX_22050019_SB_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_ovf_cnt   (perf_ovf_cnt)
`endif
    );

    typedef struct {
        logic       v;
        logic       e1;
        logic [4:0] r1;
        logic       e2;
        logic [4:0] r2;
        logic       w;
        logic [4:0] rd;
        logic       ld;
        logic       ldd;
        logic [4:0] lrd;
        logic       wb;
        logic [4:0] wrd;
        logic       fl;
        logic       x_rdy;
        logic       x_s1;
        logic       x_s2;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_stall = 0;
    int   exp_ovf = 0;

    function automatic vec_t mk(input logic v, input logic e1, input logic [4:0] r1,
                                input logic e2, input logic [4:0] r2,
                                input logic w, input logic [4:0] rd, input logic ld,
                                input logic ldd, input logic [4:0] lrd,
                                input logic wb, input logic [4:0] wrd, input logic fl,
                                input logic x_rdy, input logic x_s1, input logic x_s2);
        vec_t t;
        t.v = v; t.e1 = e1; t.r1 = r1; t.e2 = e2; t.r2 = r2;
        t.w = w; t.rd = rd; t.ld = ld; t.ldd = ldd; t.lrd = lrd;
        t.wb = wb; t.wrd = wrd; t.fl = fl;
        t.x_rdy = x_rdy; t.x_s1 = x_s1; t.x_s2 = x_s2;
        return t;
    endfunction

    task automatic apply(input vec_t t);
        id_valid = t.v;  id_rs1_en = t.e1; id_rs1 = t.r1; id_rs2_en = t.e2; id_rs2 = t.r2;
        id_rd_wen = t.w; id_rd = t.rd; id_is_load = t.ld;
        lsu_ld_done = t.ldd; lsu_rd = t.lrd; wb_valid = t.wb; wb_rd = t.wrd; flush = t.fl;
    endtask

    task automatic idle();
        apply(mk(0,0,0, 0,0, 0,0,0, 0,0, 0,0, 0, 1,0,0));
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #3;
        chk("reset id_ready", id_ready, 1);
        chk("reset stall_rs1", stall_rs1, 0);
        chk("reset stall_rs2", stall_rs2, 0);
`ifdef YSYX_22050019_SB_PERF_EN
        chk("reset perf_stall", perf_stall_cnt, 0);
        chk("reset perf_ovf", perf_ovf_cnt, 0);
`endif

        //                v e1 r1 e2 r2 w rd ld ldd lrd wb wrd fl  rdy s1 s2
        tbl.push_back(mk(1,1, 5, 0, 0, 0, 0,0, 0, 0, 0, 0, 0,  1, 0, 0)); // 0 idle read x5
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 5,1, 0, 0, 0, 0, 0,  1, 0, 0)); // 1 load x5
        tbl.push_back(mk(1,1, 5, 0, 0, 0, 0,0, 0, 0, 0, 0, 0,  0, 1, 0)); // 2 use x5
        tbl.push_back(mk(1,1, 5, 0, 0, 0, 0,0, 1, 5, 0, 0, 0,  0, 1, 0)); // 3 ld_done, still stalled
        tbl.push_back(mk(1,1, 5, 0, 0, 0, 0,0, 0, 0, 1, 5, 0,  1, 0, 0)); // 4 unblocked, retire x5
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 7,1, 0, 0, 0, 0, 0,  1, 0, 0)); // 5 load x7
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 7,0, 0, 0, 0, 0, 0,  1, 0, 0)); // 6 add x7
        tbl.push_back(mk(1,0, 0, 1, 7, 1, 7,0, 0, 0, 0, 0, 0,  1, 0, 0)); // 7 read x7, cnt7 -> 3
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 7,0, 0, 0, 0, 0, 0,  0, 0, 0)); // 8 ovf x7
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 7,0, 0, 0, 1, 7, 0,  0, 0, 0)); // 9 ovf, retire x7
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 7,0, 0, 0, 0, 0, 0,  1, 0, 0)); // 10 ready again
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 9,0, 0, 0, 0, 0, 0,  1, 0, 0)); // 11 x9 #1
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 9,0, 0, 0, 0, 0, 0,  1, 0, 0)); // 12 x9 #2
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 9,0, 0, 0, 0, 0, 0,  1, 0, 0)); // 13 x9 #3
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 9,0, 0, 0, 0, 0, 0,  0, 0, 0)); // 14 x9 ovf
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 9,0, 0, 0, 1, 9, 0,  0, 0, 0)); // 15 ovf, retire x9
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 9,0, 0, 0, 0, 0, 0,  1, 0, 0)); // 16 ready
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 3,0, 0, 0, 0, 0, 0,  1, 0, 0)); // 17 x3 cnt 1
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 3,0, 0, 0, 1, 3, 0,  1, 0, 0)); // 18 issue+retire x3
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 3,0, 0, 0, 0, 0, 0,  1, 0, 0)); // 19 cnt3 2
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 3,0, 0, 0, 0, 0, 0,  1, 0, 0)); // 20 cnt3 3
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 3,0, 0, 0, 0, 0, 0,  0, 0, 0)); // 21 ovf x3
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 4,1, 0, 0, 0, 0, 0,  1, 0, 0)); // 22 load x4
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 6,1, 0, 0, 0, 0, 0,  1, 0, 0)); // 23 load x6
        tbl.push_back(mk(1,1, 0, 1, 0, 1, 0,1, 0, 0, 0, 0, 0,  1, 0, 0)); // 24 x0 everywhere
        tbl.push_back(mk(1,1, 4, 1, 6, 0, 0,0, 0, 0, 0, 0, 0,  0, 1, 1)); // 25 both stalled
        tbl.push_back(mk(1,1, 4, 0, 6, 0, 0,0, 0, 0, 0, 0, 0,  0, 1, 0)); // 26 rs2 disabled
        tbl.push_back(mk(1,1, 4, 0, 0, 1, 4,1, 1, 6, 1, 9, 1,  1, 1, 0)); // 27 flush + issue
        tbl.push_back(mk(1,1, 4, 1, 6, 1, 4,0, 0, 0, 0, 0, 0,  1, 0, 0)); // 28 state cleared
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 3,0, 0, 0, 0, 0, 0,  1, 0, 0)); // 29 cnt3 cleared
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 8,1, 0, 0, 0, 0, 0,  1, 0, 0)); // 30 load x8
        tbl.push_back(mk(1,0, 0, 0, 0, 1, 8,1, 1, 8, 0, 0, 0,  1, 0, 0)); // 31 ld_done+load x8
        tbl.push_back(mk(1,1, 8, 0, 0, 0, 0,0, 0, 0, 0, 0, 0,  0, 1, 0)); // 32 issue won
        tbl.push_back(mk(1,1, 8, 0, 0, 0, 0,0, 1, 8, 0, 0, 0,  0, 1, 0)); // 33 ld_done x8
        tbl.push_back(mk(1,1, 8, 0, 0, 0, 0,0, 0, 0, 0, 0, 0,  1, 0, 0)); // 34 unblocked

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1 apply(tbl[i]);
            #3;
            chk($sformatf("row%0d id_ready", i), id_ready, tbl[i].x_rdy);
            chk($sformatf("row%0d stall_rs1", i), stall_rs1, tbl[i].x_s1);
            chk($sformatf("row%0d stall_rs2", i), stall_rs2, tbl[i].x_s2);
            if (tbl[i].v && !tbl[i].x_rdy && !tbl[i].fl) begin
                exp_stall++;
                if (!tbl[i].x_s1 && !tbl[i].x_s2) exp_ovf++;
            end
        end

        @(posedge clk);
        #1 idle();
        #3;
`ifdef YSYX_22050019_SB_PERF_EN
        chk("perf_stall_cnt", perf_stall_cnt, 64'(exp_stall));
        chk("perf_ovf_cnt", perf_ovf_cnt, 64'(exp_ovf));
`endif

        // Reset mid-operation drops a pending load just like flush
        @(posedge clk);
        #1 apply(mk(1,0, 0, 0, 0, 1,10,1, 0, 0, 0, 0, 0, 1,0,0));
        @(posedge clk);
        #1 apply(mk(1,1,10, 0, 0, 0, 0,0, 0, 0, 0, 0, 0, 0,1,0));
        rst_n = 1'b0;
        #3;
        chk("pre-reset stall_rs1 x10", stall_rs1, 1);
        chk("pre-reset id_ready", id_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #3;
        chk("post-reset stall_rs1 x10", stall_rs1, 0);
        chk("post-reset id_ready", id_ready, 1);
`ifdef YSYX_22050019_SB_PERF_EN
        chk("post-reset perf_stall", perf_stall_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
